embed_ram_test_master: RTL and testbench
========================================

Name: embed_ram_test_master

Overview:
- Avalon-MM master that drives the system's single-port on-chip RAM slave (32-bit data, 4-bit byteenable, 12-bit word address, 4000 words, fixed read latency 1).
- Two operations:
  - FILL: writes a deterministic pattern over a word range.
  - VERIFY: reads the range back, compares each word against the same pattern, and reports the error count and the first failing address.
- Used for power-on memory test and as a software-triggered scrubber. It sits beside the Nios II data master on the same slave port.

Parameters:
- ADDR_W, 12, word-address width of the target slave.
- DEPTH, 4000, number of valid words. Addresses wrap modulo DEPTH.
- RD_LAT, 1, fixed slave read latency in cycles (1..4).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle start request.
- op  in  1  0 = FILL, 1 = VERIFY. Sampled with start.
- base_addr  in  ADDR_W  first word address. Sampled with start.
- count  in  ADDR_W+1  number of words. Sampled with start.
- seed  in  32  pattern seed. Sampled with start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle completion pulse.
- err_count  out  ADDR_W+1  VERIFY mismatches. Saturating.
- first_err_addr  out  ADDR_W  address of the first VERIFY mismatch.
- err_flag  out  1  set if err_count != 0.
- m_address  out  ADDR_W  master word address.
- m_byteenable  out  4  always 4'hF.
- m_chipselect  out  1  high on any read or write.
- m_write  out  1  write strobe.
- m_read  out  1  read strobe.
- m_writedata  out  32  write data.
- m_readdata  in  32  read data, valid RD_LAT cycles after an accepted read.
- m_waitrequest  in  1  stall. Tie to 0 for the on-chip RAM.

Behaviour:
- Reset: all outputs 0, except m_byteenable = 4'hF. The state machine goes to IDLE and the pipeline is cleared.
- Pattern: word i (0-based) = seed + i, modulo 2^32.
- Address for word i: (base_addr + i) mod DEPTH. base_addr >= DEPTH is reduced mod DEPTH at start.
- count > DEPTH is clamped to DEPTH.

State machine:
- IDLE: waits for start.
  - On start with count == 0: go to DONE. No bus cycles.
  - Otherwise: latch the inputs, clear err_count, err_flag and first_err_addr, then go to ISSUE.
  - start while not in IDLE is ignored.
- ISSUE: presents one request per cycle.
  - A request is accepted when m_waitrequest == 0.
  - Address, data and strobes hold stable while m_waitrequest == 1.
  - The issue index increments only on acceptance.
  - After the last accepted request: FILL goes to DONE; VERIFY goes to DRAIN.
- DRAIN: waits until the RD_LAT-deep compare pipeline is empty, then goes to DONE.
- DONE: done = 1 and busy = 0 for one cycle, then go to IDLE. The strobes are already low.

Verify pipeline:
- A shift register of RD_LAT entries; each entry holds {valid, expected, addr}.
- An entry is pushed on each accepted read.
- At the output of the pipeline, when valid: compare m_readdata against expected.
- On mismatch:
  - err_count increments and saturates at all-ones.
  - first_err_addr is captured only when err_count was 0.

Timing and status:
- Throughput: 1 word/clk with no waitrequest.
- FILL of N words: done asserts N+1 cycles after the start cycle.
- VERIFY of N words: done asserts N+RD_LAT+1 cycles after the start cycle.
- Status outputs hold their values after done until the next accepted start.

Reset mid-operation:
- reset_n low aborts immediately. Strobes drop asynchronously and no further bus cycles occur.
- A partially filled range is left as is.

Decomposition:
- Package embed_ram_pkg holds:
  - op encoding constants OP_FILL and OP_VERIFY.
  - state enum.
  - DEPTH and ADDR_W defaults, shared with the RAM wrapper.
- One sub-module, embed_ram_cmp_pipe: the RD_LAT-deep {valid, expected, addr} delay line plus the compare and error accumulation.

Test Plan:
- FILL base=0x010, count=4, seed=0xA5A50000, waitrequest=0.
  - Writes to 0x010..0x013 with data 0xA5A50000..0xA5A50003 on 4 consecutive cycles.
  - done 5 cycles after start.
- VERIFY of the same range against a behavioural RAM model.
  - err_count=0, err_flag=0.
  - done 6 cycles after start.
- VERIFY after corrupting word 0x012 to 0xDEADBEEF.
  - err_count=1, first_err_addr=0x012, err_flag=1.
- Wrap: FILL base=3998, count=4, seed=0.
  - Writes to addresses 3998, 3999, 0, 1 with data 0..3.
  - count=5000 is clamped to 4000 writes.
- Waitrequest held high for 3 cycles on the second write.
  - Address and data stay stable during the stall.
  - Total of 4 writes, done delayed by 3 cycles.
  - start pulsed while busy is ignored.
- Edge and reset cases:
  - count=0: done the cycle after start, no strobes.
  - reset_n low during ISSUE: m_write drops immediately, busy=0, done never pulses.

Source files
------------

// File: rtl/embed_ram_test_master_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : embed_ram_pkg
//  Description : Shared constants and types for the embedded RAM test master
//                and the on-chip RAM wrapper.
//  Revision    : 1.0 - initial release
// ============================================================================
package embed_ram_pkg;

    // Geometry of the on-chip RAM slave
    localparam int RAM_ADDR_W = 12;
    localparam int RAM_DEPTH  = 4000;

    // Operation select, sampled with start
    localparam logic OP_FILL   = 1'b0;
    localparam logic OP_VERIFY = 1'b1;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage
`default_nettype wire

// File: rtl/embed_ram_test_master_if.sv
`default_nettype none
// ============================================================================
//  Module      : embed_ram_test_master_if
//  Description : Avalon-MM word-addressed bus between the test master and
//                the single-port on-chip RAM slave.
//  Revision    : 1.0 - initial release
// ============================================================================
interface embed_ram_test_master_if #(
    parameter int ADDR_W = embed_ram_pkg::RAM_ADDR_W
) ();
    logic [ADDR_W-1:0] m_address;
    logic [3:0]        m_byteenable;
    logic              m_chipselect;
    logic              m_write;
    logic              m_read;
    logic [31:0]       m_writedata;
    logic [31:0]       m_readdata;
    logic              m_waitrequest;

    modport master (
        output m_address, m_byteenable, m_chipselect, m_write, m_read, m_writedata,
        input  m_readdata, m_waitrequest
    );

    modport slave (
        input  m_address, m_byteenable, m_chipselect, m_write, m_read, m_writedata,
        output m_readdata, m_waitrequest
    );
endinterface
`default_nettype wire

// File: rtl/embed_ram_cmp_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : embed_ram_cmp_pipe
//  Description : Read-latency delay line of {valid, expected, addr} entries,
//                read-data compare and saturating error accumulation.
//  Revision    : 1.0 - initial release
// ============================================================================
module embed_ram_cmp_pipe #(
    parameter int ADDR_W = 12,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_clear,
    input  logic              i_push,
    input  logic [31:0]       i_exp,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_rdata,
    output logic              o_pending,
    output logic [ADDR_W:0]   o_err_count,
    output logic [ADDR_W-1:0] o_first_err_addr,
    output logic              o_err_flag
);
    // Output stage is excluded when asking whether more compares are coming
    localparam logic [RD_LAT-1:0] c_out_mask = (RD_LAT)'(1) << (RD_LAT - 1);

    logic [RD_LAT-1:0] r_vld_q, w_vld_d;
    logic [31:0]       r_exp_q  [RD_LAT];
    logic [31:0]       w_exp_d  [RD_LAT];
    logic [ADDR_W-1:0] r_addr_q [RD_LAT];
    logic [ADDR_W-1:0] w_addr_d [RD_LAT];
    logic [ADDR_W:0]   r_err_cnt_q, w_err_cnt_d;
    logic [ADDR_W-1:0] r_first_q, w_first_d;
    logic              w_mismatch;

    // Shift the delay line: stage 0 takes the new read, last stage meets read data
    always_comb begin
        w_vld_d[0]  = i_push;
        w_exp_d[0]  = i_exp;
        w_addr_d[0] = i_addr;
        for (int i = 1; i < RD_LAT; i++) begin
            w_vld_d[i]  = r_vld_q[i-1];
            w_exp_d[i]  = r_exp_q[i-1];
            w_addr_d[i] = r_addr_q[i-1];
        end
    end

    // Compare at the pipe output; first address only latched while the count is zero
    always_comb begin
        w_mismatch  = r_vld_q[RD_LAT-1] && (i_rdata != r_exp_q[RD_LAT-1]);
        w_err_cnt_d = r_err_cnt_q;
        w_first_d   = r_first_q;
        if (i_clear) begin
            w_err_cnt_d = '0;
            w_first_d   = '0;
        end else if (w_mismatch) begin
            if (r_err_cnt_q == '0) begin
                w_first_d = r_addr_q[RD_LAT-1];
            end
            if (r_err_cnt_q != '1) begin
                w_err_cnt_d = r_err_cnt_q + (ADDR_W+1)'(1);
            end
        end
    end

    // Pipeline and error state registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vld_q     <= '0;
            r_err_cnt_q <= '0;
            r_first_q   <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                r_exp_q[i]  <= '0;
                r_addr_q[i] <= '0;
            end
        end else begin
            r_vld_q     <= w_vld_d;
            r_err_cnt_q <= w_err_cnt_d;
            r_first_q   <= w_first_d;
            for (int i = 0; i < RD_LAT; i++) begin
                r_exp_q[i]  <= w_exp_d[i];
                r_addr_q[i] <= w_addr_d[i];
            end
        end
    end

    assign o_pending        = |(r_vld_q & ~c_out_mask);
    assign o_err_count      = r_err_cnt_q;
    assign o_first_err_addr = r_first_q;
    assign o_err_flag       = (r_err_cnt_q != '0);

endmodule
`default_nettype wire

// File: rtl/embed_ram_test_master.sv
`default_nettype none
// ============================================================================
//  Module      : embed_ram_test_master
//  Description : Avalon-MM master that fills a word range of the on-chip RAM
//                with seed+i, or reads it back and counts mismatches.
//  Revision    : 1.0 - initial release
// ============================================================================
module embed_ram_test_master
    import embed_ram_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DEPTH  = RAM_DEPTH,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              op,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   count,
    input  logic [31:0]       seed,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic              err_flag,
    embed_ram_test_master_if.master bus
);
    localparam logic [ADDR_W:0]   c_depth_cnt = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(DEPTH - 1);

    state_e            r_state_q, w_state_d;
    logic              r_op_q, w_op_d;
    logic [ADDR_W-1:0] r_addr_q, w_addr_d;
    logic [31:0]       r_data_q, w_data_d;
    logic [ADDR_W:0]   r_remain_q, w_remain_d;
    logic              w_issue;
    logic              w_accept;
    logic              w_start_ok;
    logic              w_pending;

    // Request handshake decode
    always_comb begin
        w_issue    = (r_state_q == ST_ISSUE);
        w_accept   = w_issue && !bus.m_waitrequest;
        w_start_ok = (r_state_q == ST_IDLE) && start && (count != '0);
    end

    // Controller: latch the job, walk the range one accepted request at a time
    always_comb begin
        w_state_d  = r_state_q;
        w_op_d     = r_op_q;
        w_addr_d   = r_addr_q;
        w_data_d   = r_data_q;
        w_remain_d = r_remain_q;
        case (r_state_q)
            ST_IDLE: begin
                if (start) begin
                    if (count == '0) begin
                        w_state_d = ST_DONE;
                    end else begin
                        w_state_d  = ST_ISSUE;
                        w_op_d     = op;
                        w_addr_d   = ADDR_W'(32'(base_addr) % 32'(DEPTH));
                        w_data_d   = seed;
                        w_remain_d = (count > c_depth_cnt) ? c_depth_cnt : count;
                    end
                end
            end
            ST_ISSUE: begin
                if (w_accept) begin
                    w_addr_d   = (r_addr_q == c_last_addr) ? '0 : r_addr_q + ADDR_W'(1);
                    w_data_d   = r_data_q + 32'd1;
                    w_remain_d = r_remain_q - (ADDR_W+1)'(1);
                    if (r_remain_q == (ADDR_W+1)'(1)) begin
                        w_state_d = (r_op_q == OP_VERIFY) ? ST_DRAIN : ST_DONE;
                    end
                end
            end
            ST_DRAIN: begin
                if (!w_pending) begin
                    w_state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_d = ST_IDLE;
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    // Controller registers; reset drops the strobes without waiting for a clock
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state_q  <= ST_IDLE;
            r_op_q     <= OP_FILL;
            r_addr_q   <= '0;
            r_data_q   <= '0;
            r_remain_q <= '0;
        end else begin
            r_state_q  <= w_state_d;
            r_op_q     <= w_op_d;
            r_addr_q   <= w_addr_d;
            r_data_q   <= w_data_d;
            r_remain_q <= w_remain_d;
        end
    end

    embed_ram_cmp_pipe #(
        .ADDR_W (ADDR_W),
        .RD_LAT (RD_LAT)
    ) u_cmp_pipe (
        .clk              (clk),
        .reset_n          (reset_n),
        .i_clear          (w_start_ok),
        .i_push           (w_accept && (r_op_q == OP_VERIFY)),
        .i_exp            (r_data_q),
        .i_addr           (r_addr_q),
        .i_rdata          (bus.m_readdata),
        .o_pending        (w_pending),
        .o_err_count      (err_count),
        .o_first_err_addr (first_err_addr),
        .o_err_flag       (err_flag)
    );

    assign bus.m_address    = r_addr_q;
    assign bus.m_writedata  = r_data_q;
    assign bus.m_byteenable = 4'hF;
    assign bus.m_chipselect = w_issue;
    assign bus.m_write      = w_issue && (r_op_q == OP_FILL);
    assign bus.m_read       = w_issue && (r_op_q == OP_VERIFY);
    assign busy             = (r_state_q == ST_ISSUE) || (r_state_q == ST_DRAIN);
    assign done             = (r_state_q == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_embed_ram_test_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_embed_ram_test_master
//  Description : Self-checking bench: behavioural RAM slave, bus scoreboard,
//                table of FILL/VERIFY jobs plus reset and edge sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_embed_ram_test_master;
    import embed_ram_pkg::*;

    localparam int AW  = 12;
    localparam int DEP = 4000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic [11:0] base_addr = '0;
    logic [12:0] count = '0;
    logic [31:0] seed = '0;
    logic        busy, done, err_flag;
    logic [12:0] err_count;
    logic [11:0] first_err_addr;

    embed_ram_test_master_if #(.ADDR_W(AW)) bus ();

    embed_ram_test_master #(.ADDR_W(AW), .DEPTH(DEP), .RD_LAT(1)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .op             (op),
        .base_addr      (base_addr),
        .count          (count),
        .seed           (seed),
        .busy           (busy),
        .done           (done),
        .err_count      (err_count),
        .first_err_addr (first_err_addr),
        .err_flag       (err_flag),
        .bus            (bus)
    );

    always #5 clk = ~clk;

    // Behavioural RAM slave (read latency 1) and waitrequest generator
    logic [31:0] mem [DEP];
    logic [31:0] rdata_q = '0;
    logic        corrupt_req = 1'b0;
    logic        stall_en = 1'b0;
    int          acc_cnt = 0;
    int          stall_cyc = 0;

    assign bus.m_readdata    = rdata_q;
    assign bus.m_waitrequest = stall_en && bus.m_chipselect && (acc_cnt == 1) && (stall_cyc < 3);

    always @(posedge clk) begin
        if (bus.m_chipselect && !bus.m_waitrequest) begin
            if (bus.m_write) mem[bus.m_address] <= bus.m_writedata;
            if (bus.m_read)  rdata_q <= mem[bus.m_address];
        end
        if (corrupt_req) mem[12'h012] <= 32'hDEADBEEF;
        if (!bus.m_chipselect) begin
            acc_cnt   <= 0;
            stall_cyc <= 0;
        end else if (bus.m_waitrequest) begin
            stall_cyc <= stall_cyc + 1;
        end else begin
            acc_cnt <= acc_cnt + 1;
        end
    end

    typedef struct packed {
        logic        wr;
        logic [11:0] addr;
        logic [31:0] data;
    } txn_t;

    typedef struct {
        logic        op;
        logic [11:0] base;
        logic [12:0] cnt;
        logic [31:0] seed;
        logic        corrupt;
        logic        stall;
        logic        poke;
        int          exp_lat;
        int          exp_err;
        logic [11:0] exp_first;
        logic        exp_flag;
    } vec_t;

    txn_t sb[$];
    vec_t vecs[10];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic o, input logic [11:0] b, input logic [12:0] c,
                                input logic [31:0] s, input logic cor, input logic stl,
                                input logic pk, input int lat, input int er,
                                input logic [11:0] fe, input logic fl);
        vec_t v;
        v.op = o; v.base = b; v.cnt = c; v.seed = s;
        v.corrupt = cor; v.stall = stl; v.poke = pk;
        v.exp_lat = lat; v.exp_err = er; v.exp_first = fe; v.exp_flag = fl;
        return v;
    endfunction

    // Run one job: predict its bus traffic, start it, check traffic, latency and status
    task automatic run_vec(input vec_t v, input int idx);
        int   n, b, lat;
        txn_t e;
        n = (v.cnt > 13'(DEP)) ? DEP : int'(v.cnt);
        b = int'(v.base) % DEP;
        for (int i = 0; i < n; i++) begin
            e.wr   = (v.op == OP_FILL);
            e.addr = 12'((b + i) % DEP);
            e.data = v.seed + 32'(i);
            sb.push_back(e);
        end
        stall_en = v.stall;
        if (v.corrupt) begin
            @(posedge clk); #1 corrupt_req = 1'b1;
            @(posedge clk); #1 corrupt_req = 1'b0;
        end
        @(posedge clk); #1;
        start = 1'b1; op = v.op; base_addr = v.base; count = v.cnt; seed = v.seed;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1;
        for (int k = 1; k <= n + 40; k++) begin
            @(negedge clk);
            if (k == 1) check($sformatf("v%0d busy_after_start", idx), busy, 1'b1);
            if (v.poke && k == 3) begin
                start = 1'b1; op = OP_VERIFY; count = 13'd1;
            end else if (v.poke && k == 4) begin
                start = 1'b0;
            end
            if (bus.m_chipselect) begin
                if (sb.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL v%0d extra_bus_cycle: addr %0h, none expected", idx, bus.m_address);
                end else begin
                    e = sb[0];
                    check($sformatf("v%0d bus_write", idx), bus.m_write, e.wr);
                    check($sformatf("v%0d bus_read", idx), bus.m_read, !e.wr);
                    check($sformatf("v%0d bus_addr", idx), bus.m_address, e.addr);
                    if (e.wr) check($sformatf("v%0d bus_wdata", idx), bus.m_writedata, e.data);
                    if (!bus.m_waitrequest) void'(sb.pop_front());
                end
            end
            if (done) begin
                lat = k;
                break;
            end
        end
        if (lat < 0) begin
            n_cmp++; n_bad++;
            $display("FAIL v%0d done_timeout: got none expected %0d", idx, v.exp_lat);
        end else begin
            check($sformatf("v%0d done_latency", idx), lat, v.exp_lat);
        end
        check($sformatf("v%0d busy_at_done", idx), busy, 1'b0);
        check($sformatf("v%0d err_count", idx), err_count, v.exp_err);
        check($sformatf("v%0d err_flag", idx), err_flag, v.exp_flag);
        if (v.exp_flag) check($sformatf("v%0d first_err_addr", idx), first_err_addr, v.exp_first);
        check($sformatf("v%0d words_left", idx), sb.size(), 0);
        sb.delete();
        stall_en = 1'b0;
        @(negedge clk);
        check($sformatf("v%0d done_one_cycle", idx), done, 1'b0);
        check($sformatf("v%0d err_hold", idx), err_count, v.exp_err);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = mk(OP_FILL,   12'h010, 13'd4,    32'hA5A50000, 0, 0, 0, 5,    0,    12'h000, 0);
        vecs[1] = mk(OP_VERIFY, 12'h010, 13'd4,    32'hA5A50000, 0, 0, 0, 6,    0,    12'h000, 0);
        vecs[2] = mk(OP_VERIFY, 12'h010, 13'd4,    32'hA5A50000, 1, 0, 0, 6,    1,    12'h012, 1);
        vecs[3] = mk(OP_FILL,   12'd3998, 13'd4,   32'h00000000, 0, 0, 0, 5,    0,    12'h000, 0);
        vecs[4] = mk(OP_VERIFY, 12'd3998, 13'd4,   32'h00000000, 0, 0, 0, 6,    0,    12'h000, 0);
        vecs[5] = mk(OP_FILL,   12'h100, 13'd4,    32'h11110000, 0, 1, 1, 8,    0,    12'h000, 0);
        vecs[6] = mk(OP_FILL,   12'd4090, 13'd3,   32'hFFFFFFFE, 0, 0, 0, 4,    0,    12'h000, 0);
        vecs[7] = mk(OP_VERIFY, 12'd4090, 13'd3,   32'hFFFFFFFE, 0, 0, 0, 5,    0,    12'h000, 0);
        vecs[8] = mk(OP_FILL,   12'h000, 13'd5000, 32'h00001000, 0, 0, 0, 4001, 0,    12'h000, 0);
        vecs[9] = mk(OP_VERIFY, 12'd5,   13'd4000, 32'h00001001, 0, 0, 0, 4002, 4000, 12'd5,   1);

        // Reset state
        repeat (3) @(negedge clk);
        check("rst busy", busy, 1'b0);
        check("rst done", done, 1'b0);
        check("rst err_count", err_count, 0);
        check("rst first_err_addr", first_err_addr, 0);
        check("rst err_flag", err_flag, 1'b0);
        check("rst m_chipselect", bus.m_chipselect, 1'b0);
        check("rst m_write", bus.m_write, 1'b0);
        check("rst m_read", bus.m_read, 1'b0);
        check("rst m_address", bus.m_address, 0);
        check("rst m_writedata", bus.m_writedata, 0);
        check("rst m_byteenable", bus.m_byteenable, 4'hF);
        @(posedge clk); #1 reset_n = 1'b1;

        for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

        // count == 0: done on the next cycle, no bus activity
        @(posedge clk); #1;
        start = 1'b1; op = OP_FILL; base_addr = 12'h020; count = 13'd0; seed = 32'h0;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        check("cnt0 done", done, 1'b1);
        check("cnt0 busy", busy, 1'b0);
        check("cnt0 chipselect", bus.m_chipselect, 1'b0);
        @(negedge clk);
        check("cnt0 done_drop", done, 1'b0);
        check("cnt0 chipselect_after", bus.m_chipselect, 1'b0);

        // Reset during ISSUE aborts at once
        @(posedge clk); #1;
        start = 1'b1; op = OP_FILL; base_addr = 12'h200; count = 13'd8; seed = 32'h0;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort m_write_before", bus.m_write, 1'b1);
        #1 reset_n = 1'b0;
        #1;
        check("abort m_write", bus.m_write, 1'b0);
        check("abort m_chipselect", bus.m_chipselect, 1'b0);
        check("abort busy", busy, 1'b0);
        @(posedge clk); #1 reset_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check($sformatf("abort no_done c%0d", k), done, 1'b0);
            check($sformatf("abort no_strobe c%0d", k), bus.m_chipselect, 1'b0);
        end
        check("abort err_count", err_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
